// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter: arbitrates the single register-file write port between core
// writebacks and buffered load returns, registers the writeback-mux controls and
// keeps a per-register load scoreboard for RAW/WAW hazard detection.
//
// Ports:
//   clk, rst                      clock, async active-high reset
//   core_wb_valid/rd/sel          core writeback request (held until core_wb_ready)
//   core_wb_ready                 comb: core request granted this cycle
//   ld_issue_valid/rd             load issued to memory (sets scoreboard bit)
//   ld_ret_valid/rd/data          load data returning from memory
//   ld_ret_ready                  comb: one-entry load buffer can accept
//   chk_rs1/chk_rs2, raw_stall    hazard check against registered scoreboard
//   wb_sel, wb_load_data          registered writeback mux controls / load data
//   rf_we, rf_rd                  registered register-file write enable/address
//   pending                       registered scoreboard, bit 0 always 0
module wb_port_arbiter #(
    parameter int unsigned MAX_LD_STREAK = 2,
    parameter int unsigned XLEN          = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            core_wb_valid,
    input  logic [4:0]      core_wb_rd,
    input  logic [2:0]      core_wb_sel,
    output logic            core_wb_ready,
    input  logic            ld_issue_valid,
    input  logic [4:0]      ld_issue_rd,
    input  logic            ld_ret_valid,
    input  logic [4:0]      ld_ret_rd,
    input  logic [XLEN-1:0] ld_ret_data,
    output logic            ld_ret_ready,
    input  logic [4:0]      chk_rs1,
    input  logic [4:0]      chk_rs2,
    output logic            raw_stall,
    output logic [2:0]      wb_sel,
    output logic [XLEN-1:0] wb_load_data,
    output logic            rf_we,
    output logic [4:0]      rf_rd,
    output logic [31:0]     pending
);

    localparam int unsigned STREAK_W = (MAX_LD_STREAK < 1) ? 1 : $clog2(MAX_LD_STREAK + 1);
    localparam logic [2:0]  SEL_LOAD = 3'b001;

    // State registers
    logic                buf_valid_q, buf_valid_d;
    logic [4:0]          buf_rd_q, buf_rd_d;
    logic [XLEN-1:0]     buf_data_q, buf_data_d;
    logic [STREAK_W-1:0] streak_q, streak_d;
    logic [31:0]         pending_q, pending_d;
    logic                rf_we_q, rf_we_d;
    logic [4:0]          rf_rd_q, rf_rd_d;
    logic [2:0]          wb_sel_q, wb_sel_d;
    logic [XLEN-1:0]     wb_load_data_q, wb_load_data_d;

    logic core_elig, streak_max, grant_ld, grant_core, accept;

    // Arbitration: load wins unless it has starved an eligible core request.
    always_comb begin
        core_elig  = core_wb_valid && !pending_q[core_wb_rd];
        streak_max = (streak_q == STREAK_W'(MAX_LD_STREAK));
        grant_ld   = buf_valid_q && !(core_elig && streak_max);
        grant_core = core_elig && !grant_ld;
        accept     = ld_ret_valid && (!buf_valid_q || grant_ld);
    end

    assign core_wb_ready = grant_core;
    assign ld_ret_ready  = !buf_valid_q || grant_ld;
    // pending_q[0] is held at zero, so x0 sources never stall.
    assign raw_stall     = pending_q[chk_rs1] || pending_q[chk_rs2];

    // Next-state for buffer, streak, scoreboard and write stage.
    always_comb begin
        buf_valid_d    = buf_valid_q;
        buf_rd_d       = buf_rd_q;
        buf_data_d     = buf_data_q;
        streak_d       = streak_q;
        pending_d      = pending_q;
        rf_we_d        = 1'b0;
        rf_rd_d        = rf_rd_q;
        wb_sel_d       = wb_sel_q;
        wb_load_data_d = wb_load_data_q;

        // Drain then refill so a same-cycle accept keeps the buffer full.
        if (grant_ld) begin
            buf_valid_d = 1'b0;
        end
        if (accept) begin
            buf_valid_d = 1'b1;
            buf_rd_d    = ld_ret_rd;
            buf_data_d  = ld_ret_data;
        end

        if (grant_core || !core_wb_valid) begin
            streak_d = '0;
        end else if (grant_ld && !streak_max) begin
            streak_d = streak_q + STREAK_W'(1);
        end

        // Clear before set so an issue to the draining rd keeps the bit set.
        if (grant_ld) begin
            pending_d[buf_rd_q] = 1'b0;
        end
        if (ld_issue_valid && (ld_issue_rd != 5'd0)) begin
            pending_d[ld_issue_rd] = 1'b1;
        end
        pending_d[0] = 1'b0;

        if (grant_ld) begin
            rf_we_d        = (buf_rd_q != 5'd0);
            rf_rd_d        = buf_rd_q;
            wb_sel_d       = SEL_LOAD;
            wb_load_data_d = buf_data_q;
        end else if (grant_core) begin
            rf_we_d  = (core_wb_rd != 5'd0);
            rf_rd_d  = core_wb_rd;
            wb_sel_d = core_wb_sel;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            buf_valid_q    <= 1'b0;
            buf_rd_q       <= '0;
            buf_data_q     <= '0;
            streak_q       <= '0;
            pending_q      <= '0;
            rf_we_q        <= 1'b0;
            rf_rd_q        <= '0;
            wb_sel_q       <= '0;
            wb_load_data_q <= '0;
        end else begin
            buf_valid_q    <= buf_valid_d;
            buf_rd_q       <= buf_rd_d;
            buf_data_q     <= buf_data_d;
            streak_q       <= streak_d;
            pending_q      <= pending_d;
            rf_we_q        <= rf_we_d;
            rf_rd_q        <= rf_rd_d;
            wb_sel_q       <= wb_sel_d;
            wb_load_data_q <= wb_load_data_d;
        end
    end

    assign rf_we        = rf_we_q;
    assign rf_rd        = rf_rd_q;
    assign wb_sel       = wb_sel_q;
    assign wb_load_data = wb_load_data_q;
    assign pending      = pending_q;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed bench for wb_port_arbiter: expected write-stage records are queued
// when each cycle's stimulus is driven and compared after the clock edge.
module tb_wb_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        core_wb_valid;
    logic [4:0]  core_wb_rd;
    logic [2:0]  core_wb_sel;
    logic        core_wb_ready;
    logic        ld_issue_valid;
    logic [4:0]  ld_issue_rd;
    logic        ld_ret_valid;
    logic [4:0]  ld_ret_rd;
    logic [31:0] ld_ret_data;
    logic        ld_ret_ready;
    logic [4:0]  chk_rs1;
    logic [4:0]  chk_rs2;
    logic        raw_stall;
    logic [2:0]  wb_sel;
    logic [31:0] wb_load_data;
    logic        rf_we;
    logic [4:0]  rf_rd;
    logic [31:0] pending;

    wb_port_arbiter #(.MAX_LD_STREAK(2), .XLEN(32)) dut (
        .clk(clk), .rst(rst),
        .core_wb_valid(core_wb_valid), .core_wb_rd(core_wb_rd),
        .core_wb_sel(core_wb_sel), .core_wb_ready(core_wb_ready),
        .ld_issue_valid(ld_issue_valid), .ld_issue_rd(ld_issue_rd),
        .ld_ret_valid(ld_ret_valid), .ld_ret_rd(ld_ret_rd),
        .ld_ret_data(ld_ret_data), .ld_ret_ready(ld_ret_ready),
        .chk_rs1(chk_rs1), .chk_rs2(chk_rs2), .raw_stall(raw_stall),
        .wb_sel(wb_sel), .wb_load_data(wb_load_data),
        .rf_we(rf_we), .rf_rd(rf_rd), .pending(pending)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        we;
        logic [4:0]  rd;
        logic [2:0]  sel;
        logic [31:0] data;
    } wr_t;

    wr_t         exp_q[$];
    int          n_vec = 0;
    int          n_err = 0;
    logic [4:0]  hold_rd;
    logic [2:0]  hold_sel;
    logic [31:0] hold_data;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic push_none();
        exp_q.push_back({1'b0, hold_rd, hold_sel, hold_data});
    endtask

    task automatic push_core(input logic [4:0] rd, input logic [2:0] sel);
        hold_rd  = rd;
        hold_sel = sel;
        exp_q.push_back({rd != 5'd0, hold_rd, hold_sel, hold_data});
    endtask

    task automatic push_ld(input logic [4:0] rd, input logic [31:0] data);
        hold_rd   = rd;
        hold_sel  = 3'b001;
        hold_data = data;
        exp_q.push_back({rd != 5'd0, hold_rd, hold_sel, hold_data});
    endtask

    // Advance one clock and compare the write stage with the oldest queued record.
    task automatic step(input string tag);
        wr_t e;
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            chk({tag, ".queue"}, 32'd0, 32'd1);
        end else begin
            e = exp_q.pop_front();
            chk({tag, ".rf_we"},  32'(rf_we),  32'(e.we));
            chk({tag, ".rf_rd"},  32'(rf_rd),  32'(e.rd));
            chk({tag, ".wb_sel"}, 32'(wb_sel), 32'(e.sel));
            chk({tag, ".wb_data"}, wb_load_data, e.data);
        end
    endtask

    task automatic idle_inputs();
        core_wb_valid  = 1'b0;
        core_wb_rd     = 5'd0;
        core_wb_sel    = 3'b000;
        ld_issue_valid = 1'b0;
        ld_issue_rd    = 5'd0;
        ld_ret_valid   = 1'b0;
        ld_ret_rd      = 5'd0;
        ld_ret_data    = 32'd0;
        chk_rs1        = 5'd0;
        chk_rs2        = 5'd0;
    endtask

    logic [4:0]  buf_rd, cur_rd;
    logic [31:0] buf_data, cur_data;
    logic        is_c;

    initial begin
        rst = 1'b1;
        idle_inputs();
        hold_rd = 5'd0; hold_sel = 3'b000; hold_data = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("rst.rf_we", 32'(rf_we), 32'd0);
        chk("rst.pending", pending, 32'd0);
        chk("rst.wb_data", wb_load_data, 32'd0);
        chk("rst.ld_ret_ready", 32'(ld_ret_ready), 32'd1);

        // Core-only request
        core_wb_valid = 1'b1; core_wb_rd = 5'd5; core_wb_sel = 3'b011;
        #1;
        chk("core.ready", 32'(core_wb_ready), 32'd1);
        push_core(5'd5, 3'b011);
        step("core");
        idle_inputs();

        // Load issue, then return and grant
        ld_issue_valid = 1'b1; ld_issue_rd = 5'd7; chk_rs1 = 5'd7;
        #1;
        chk("issue.raw_same_cycle", 32'(raw_stall), 32'd0);
        push_none();
        step("issue");
        ld_issue_valid = 1'b0;
        #1;
        chk("issue.pending", pending, 32'h0000_0080);
        chk("issue.raw_stall", 32'(raw_stall), 32'd1);
        ld_ret_valid = 1'b1; ld_ret_rd = 5'd7; ld_ret_data = 32'hDEAD_BEEF;
        #1;
        chk("ret.ready", 32'(ld_ret_ready), 32'd1);
        push_none();
        step("ret_fill");
        ld_ret_valid = 1'b0;
        push_ld(5'd7, 32'hDEAD_BEEF);
        step("ret_grant");
        chk("ret.pending", pending, 32'd0);
        chk("ret.raw_stall", 32'(raw_stall), 32'd0);
        idle_inputs();

        // Core write to x0
        core_wb_valid = 1'b1; core_wb_rd = 5'd0; core_wb_sel = 3'b010;
        #1;
        chk("x0.ready", 32'(core_wb_ready), 32'd1);
        push_core(5'd0, 3'b010);
        step("x0");
        idle_inputs();

        // Starvation guard: expect L, L, C, L, L, C
        ld_ret_valid = 1'b1; ld_ret_rd = 5'd10; ld_ret_data = 32'hA000_0010;
        push_none();
        step("starve_fill");
        buf_rd = 5'd10; buf_data = 32'hA000_0010;
        cur_rd = 5'd11; cur_data = 32'hA000_0011;
        for (int i = 0; i < 6; i++) begin
            is_c = (i == 2) || (i == 5);
            core_wb_valid = 1'b1; core_wb_rd = 5'd3; core_wb_sel = 3'b000;
            ld_ret_valid = 1'b1; ld_ret_rd = cur_rd; ld_ret_data = cur_data;
            #1;
            chk($sformatf("starve%0d.core_ready", i), 32'(core_wb_ready), 32'(is_c));
            chk($sformatf("starve%0d.ld_ret_ready", i), 32'(ld_ret_ready), 32'(!is_c));
            if (is_c) begin
                push_core(5'd3, 3'b000);
            end else begin
                push_ld(buf_rd, buf_data);
                buf_rd = cur_rd; buf_data = cur_data;
                cur_rd = cur_rd + 5'd1; cur_data = cur_data + 32'd1;
            end
            step($sformatf("starve%0d", i));
        end
        idle_inputs();
        push_ld(buf_rd, buf_data);
        step("starve_drain");

        // WAW block on rd 9
        ld_issue_valid = 1'b1; ld_issue_rd = 5'd9;
        push_none();
        step("waw_issue");
        idle_inputs();
        chk("waw.pending", pending, 32'h0000_0200);
        core_wb_valid = 1'b1; core_wb_rd = 5'd9; core_wb_sel = 3'b100;
        ld_ret_valid = 1'b1; ld_ret_rd = 5'd9; ld_ret_data = 32'h0000_0099;
        #1;
        chk("waw1.core_ready", 32'(core_wb_ready), 32'd0);
        push_none();
        step("waw1");
        ld_ret_valid = 1'b0;
        #1;
        chk("waw2.core_ready", 32'(core_wb_ready), 32'd0);
        push_ld(5'd9, 32'h0000_0099);
        step("waw2");
        #1;
        chk("waw3.core_ready", 32'(core_wb_ready), 32'd1);
        push_core(5'd9, 3'b100);
        step("waw3");
        idle_inputs();

        // Issue and grant of rd 4 in the same cycle: set wins
        ld_issue_valid = 1'b1; ld_issue_rd = 5'd4;
        push_none();
        step("col_issue");
        ld_issue_valid = 1'b0;
        ld_ret_valid = 1'b1; ld_ret_rd = 5'd4; ld_ret_data = 32'h0000_0044;
        push_none();
        step("col_fill");
        ld_ret_valid = 1'b0;
        ld_issue_valid = 1'b1; ld_issue_rd = 5'd4;
        push_ld(5'd4, 32'h0000_0044);
        step("col_grant");
        chk("col.pending", pending, 32'h0000_0010);

        // Build mid-operation state: buffer full, pending[5], rf_we high
        ld_issue_valid = 1'b1; ld_issue_rd = 5'd5;
        ld_ret_valid = 1'b1; ld_ret_rd = 5'd4; ld_ret_data = 32'h0000_0055;
        push_none();
        step("mid_fill");
        ld_issue_valid = 1'b0;
        ld_ret_valid = 1'b1; ld_ret_rd = 5'd6; ld_ret_data = 32'h0000_0066;
        push_ld(5'd4, 32'h0000_0055);
        step("mid_grant");
        chk("mid.pending", pending, 32'h0000_0020);
        chk("mid.ld_ret_ready", 32'(ld_ret_ready), 32'd1);
        idle_inputs();

        // Asynchronous reset between edges
        #2;
        rst = 1'b1;
        #1;
        chk("arst.rf_we", 32'(rf_we), 32'd0);
        chk("arst.rf_rd", 32'(rf_rd), 32'd0);
        chk("arst.wb_sel", 32'(wb_sel), 32'd0);
        chk("arst.wb_data", wb_load_data, 32'd0);
        chk("arst.pending", pending, 32'd0);
        chk("arst.ld_ret_ready", 32'(ld_ret_ready), 32'd1);
        chk("arst.core_ready", 32'(core_wb_ready), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        hold_rd = 5'd0; hold_sel = 3'b000; hold_data = 32'd0;
        // An emptied buffer produces no write after reset.
        push_none();
        step("post_rst");
        chk("post_rst.pending", pending, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/wb_port_arbiter.md
Name: wb_port_arbiter

Overview:
Arbiter and sequencer for the single register-file write port and the writeback-source mux in front of it. The port has two requesters: core writebacks (ALU result, PC+4, PC+IMM, B-type IMM) and load returns from a variable-latency data memory. The block picks one requester per cycle and buffers one load return. It drives the mux select code, the registered load data and the register-file write enable and address. A load scoreboard gives the core RAW and WAW stall information.

Parameters:
MAX_LD_STREAK, 2, max consecutive load grants while a core request waits; the core is then granted once.
XLEN, 32, data width.

Ports:
clk  input  1  clock; all state updates on rising edge.
rst  input  1  asynchronous active-high reset.
core_wb_valid  input  1  core writeback request.
core_wb_rd  input  5  core destination register.
core_wb_sel  input  3  source code: 000 ALU, 010 PC+4, 011 PC+IMM, 100 B-imm. 001 is illegal from the core.
core_wb_ready  output  1  combinational; core request granted this cycle.
ld_issue_valid  input  1  load issued to memory this cycle.
ld_issue_rd  input  5  destination of the issued load.
ld_ret_valid  input  1  load data returning.
ld_ret_rd  input  5  destination of the returning load.
ld_ret_data  input  XLEN  returned load data.
ld_ret_ready  output  1  combinational; load buffer can accept.
chk_rs1  input  5  core source register 1, for hazard check.
chk_rs2  input  5  core source register 2, for hazard check.
raw_stall  output  1  combinational; chk_rs1 or chk_rs2 is nonzero and pending.
wb_sel  output  3  registered; mux select code.
wb_load_data  output  XLEN  registered; drives the mux load_result input.
rf_we  output  1  registered; register-file write enable.
rf_rd  output  5  registered; register-file write address.
pending  output  32  registered; scoreboard vector, bit 0 is always 0.

Behaviour:
- Reset (async, any time, including mid-arbitration) clears:
  - rf_we=0, rf_rd=0, wb_sel=000, wb_load_data=0
  - pending=0, load buffer empty, streak counter=0
  - Combinational outputs follow from the cleared state.
- Load buffer (1 entry: valid, rd, data):
  - ld_ret_ready = buffer empty OR buffered load is granted this cycle.
  - Accept = ld_ret_valid && ld_ret_ready. Accept and drain in the same cycle refills the buffer in that cycle.
  - A return arriving into an empty buffer is not eligible for grant until the next cycle.
- Requesters each cycle:
  - L = buffer valid.
  - C = core_wb_valid && !pending[core_wb_rd]. A WAW-blocked core request is not eligible.
- Grant rules:
  - L only: grant load.
  - C only: grant core.
  - Both: grant load unless streak==MAX_LD_STREAK, then grant core.
- Streak counter:
  - +1 on a load grant while core_wb_valid is high.
  - Reset to 0 on a core grant or when core_wb_valid is low.
  - Saturates at MAX_LD_STREAK.
- core_wb_ready=1 only on a core grant. The core holds valid, rd and sel stable until ready.
- Write stage (1-cycle latency, registered at the grant edge):
  - Load grant: rf_we=(rd!=0), rf_rd=rd, wb_sel=001, wb_load_data=buffer data.
  - Core grant: rf_we=(core_wb_rd!=0), rf_rd=core_wb_rd, wb_sel=core_wb_sel; wb_load_data holds its value.
  - No grant: rf_we=0; rf_rd, wb_sel and wb_load_data hold.
  - An illegal core_wb_sel=001 is passed through unchanged; the core is responsible for never sending it.
- Scoreboard:
  - ld_issue_valid with rd!=0 sets pending[rd].
  - A load grant clears pending[buffer rd].
  - Set and clear on the same rd in the same cycle: set wins.
  - Issue to x0 is ignored. pending[0] is constant 0.
- raw_stall uses the current registered pending value; a same-cycle issue or clear is not visible.

Test Plan:
- Reset mid-operation: buffer full, pending=0x0000_0020, rf_we=1 at the moment of reset -> all outputs 0 in the same cycle, before the next clk edge.
- Core-only request: valid, rd=5, sel=011 -> ready=1 the same cycle; next cycle rf_we=1, rf_rd=5, wb_sel=011.
- Load path:
  - Issue rd=7 -> pending[7]=1, and raw_stall=1 with chk_rs1=7.
  - Return rd=7, data 0xDEADBEEF -> one cycle later granted; the following cycle rf_we=1, rf_rd=7, wb_sel=001, wb_load_data=0xDEADBEEF, pending[7]=0.
- Conflict and starvation guard, MAX_LD_STREAK=2: core valid rd=3 held, loads returning every cycle -> grant order L, L, C, L, L, C; ld_ret_ready=0 in the cycle the core is granted.
- WAW block: pending[9]=1, core request to rd=9 -> ready stays 0 until the load to 9 is granted; the core is granted the next cycle.
- x0 and collision cases:
  - Core rd=0 -> ready=1 and rf_we=0.
  - Issue rd=4 in the same cycle a buffered rd=4 load is granted -> pending[4] stays 1.
